// File: rtl/pdm_pkg.sv
// pdm_pkg: shared types and defaults for the PDM microphone clock controller
package pdm_pkg;
  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_e;
  localparam int DIV_W_DEF = 8;
  function automatic int div_default(input int in_freq, input int out_freq);
    return in_freq / out_freq / 2;
  endfunction
endpackage

// File: rtl/pdm_mclk_ctrl_if.sv
// pdm_mclk_ctrl_if: divider configuration port of the PDM clock controller
interface pdm_mclk_ctrl_if #(parameter int DIV_W = pdm_pkg::DIV_W_DEF);
  logic cfg_wr;
  logic [DIV_W-1:0] cfg_div;
  logic cfg_pending;
  logic [DIV_W-1:0] div_active;
  modport master(output cfg_wr, cfg_div, input cfg_pending, div_active);
  modport slave(input cfg_wr, cfg_div, output cfg_pending, div_active);
endinterface

// File: rtl/pdm_strobe_delay.sv
// pdm_strobe_delay: fixed-length pulse delay line, DLY = 0 passes straight through
module pdm_strobe_delay #(parameter int DLY = 3) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  if (DLY == 0) begin : g_thru
    assign q = d;
  end else begin : g_sr
    logic [DLY-1:0] sr_q, sr_d;
    always_comb sr_d = DLY'({sr_q, d});
    always_ff @(posedge clk) sr_q <= rst ? '0 : sr_d;
    assign q = sr_q[DLY-1];
  end
endmodule

// File: rtl/pdm_mclk_ctrl.sv
// pdm_mclk_ctrl: programmable glitch-free M_CLK generator with delayed
// stereo sample strobes and a decimation frame tick
module pdm_mclk_ctrl
  import pdm_pkg::*;
#(
  parameter int INPUT_FREQ  = 100_000_000,
  parameter int OUTPUT_FREQ = 2_400_000,
  parameter int DIV_W       = DIV_W_DEF,
  parameter int DIV_DEFAULT = div_default(INPUT_FREQ, OUTPUT_FREQ),
  parameter int SAMPLE_DLY  = 3,
  parameter int DECIM       = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  pdm_mclk_ctrl_if.slave cfg,
  output logic M_CLK,
  output logic m_clk_rising,
  output logic m_clk_falling,
  output logic sample_l,
  output logic sample_r,
  output logic frame_tick,
  output logic running
);
  localparam int RC_W = DECIM > 1 ? $clog2(DECIM) : 1;
  state_e st_q, st_d;
  logic [DIV_W-1:0] cnt_q, cnt_d, div_q, div_d, pend_q, pend_d, wr_val;
  logic [RC_W-1:0] rc_q, rc_d;
  logic pv_q, pv_d, mclk_q, mclk_d, rise_q, rise_d, fall_q, fall_d, frame_q, frame_d, run_q, run_d, last;
  always_comb begin
    wr_val = cfg.cfg_div == '0 ? DIV_W'(1) : cfg.cfg_div;
    last = cnt_q == div_q - DIV_W'(1);
    st_d = st_q;
    cnt_d = cnt_q + DIV_W'(1);
    div_d = div_q;
    pend_d = pend_q;
    pv_d = pv_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    case (st_q)
      IDLE: begin
        cnt_d = '0;
        st_d = en ? HIGH : IDLE;
        rise_d = en;
      end
      HIGH: if (last) begin
        cnt_d = '0;
        st_d = LOW;
        fall_d = 1'b1;
      end
      LOW: if (last) begin
        cnt_d = '0;
        div_d = pv_q ? pend_q : div_q;
        pv_d = 1'b0;
        st_d = en ? HIGH : IDLE;
        rise_d = en;
      end
      default: st_d = IDLE;
    endcase
    // idle writes take effect at once; running writes wait for the LOW end
    if (cfg.cfg_wr && st_q == IDLE) div_d = wr_val;
    if (cfg.cfg_wr && st_q != IDLE) begin
      pend_d = wr_val;
      pv_d = 1'b1;
    end
    frame_d = rise_d && rc_q == RC_W'(DECIM - 1);
    rc_d = st_d == IDLE ? '0 : !rise_d ? rc_q : frame_d ? '0 : rc_q + RC_W'(1);
    mclk_d = st_d == HIGH;
    run_d = st_d != IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= IDLE;
      cnt_q <= '0;
      div_q <= DIV_W'(DIV_DEFAULT);
      pend_q <= '0;
      pv_q <= 1'b0;
      rc_q <= '0;
      mclk_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      frame_q <= 1'b0;
      run_q <= 1'b0;
    end else begin
      st_q <= st_d;
      cnt_q <= cnt_d;
      div_q <= div_d;
      pend_q <= pend_d;
      pv_q <= pv_d;
      rc_q <= rc_d;
      mclk_q <= mclk_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      frame_q <= frame_d;
      run_q <= run_d;
    end
  end
  pdm_strobe_delay #(.DLY(SAMPLE_DLY)) u_dly_l (.clk(clk), .rst(rst), .d(rise_q), .q(sample_l));
  pdm_strobe_delay #(.DLY(SAMPLE_DLY)) u_dly_r (.clk(clk), .rst(rst), .d(fall_q), .q(sample_r));
  assign M_CLK = mclk_q;
  assign m_clk_rising = rise_q;
  assign m_clk_falling = fall_q;
  assign frame_tick = frame_q;
  assign running = run_q;
  assign cfg.cfg_pending = pv_q;
  assign cfg.div_active = div_q;
endmodule

// File: tb/tb_pdm_mclk_ctrl.sv
// tb_pdm_mclk_ctrl: two controllers (DECIM 64 and 4) checked every cycle
// against a period-position reference model
module tb_pdm_mclk_ctrl;
  localparam int DW = 8;
  localparam int DLY = 3;
  logic clk = 1'b0;
  logic rst, en;
  logic [1:0] mclk, rise, fall, sl, sr, frame, run;
  int vectors = 0;
  int miscompares = 0;
  bit m_run, m_pv, m_rise, m_fall, m_fr64, m_fr4;
  int m_t, m_div, m_pend, m_rises;
  logic [DLY-1:0] rh, fh;
  always #5 clk = ~clk;
  pdm_mclk_ctrl_if #(.DIV_W(DW)) ifa ();
  pdm_mclk_ctrl_if #(.DIV_W(DW)) ifb ();
  assign ifb.cfg_wr = ifa.cfg_wr;
  assign ifb.cfg_div = ifa.cfg_div;
  pdm_mclk_ctrl #(.DIV_W(DW), .SAMPLE_DLY(DLY), .DECIM(64)) dut (
    .clk(clk), .rst(rst), .en(en), .cfg(ifa.slave), .M_CLK(mclk[0]), .m_clk_rising(rise[0]),
    .m_clk_falling(fall[0]), .sample_l(sl[0]), .sample_r(sr[0]), .frame_tick(frame[0]), .running(run[0]));
  pdm_mclk_ctrl #(.DIV_W(DW), .SAMPLE_DLY(DLY), .DECIM(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .cfg(ifb.slave), .M_CLK(mclk[1]), .m_clk_rising(rise[1]),
    .m_clk_falling(fall[1]), .sample_l(sl[1]), .sample_r(sr[1]), .frame_tick(frame[1]), .running(run[1]));
  task automatic chk(input string tag, input int i, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s[dut%0d] observed=%0h expected=%0h at %0t", tag, i, obs, exp, $time);
    end
  endtask
  task automatic start_period();
    m_run = 1'b1;
    m_t = 0;
    m_rise = 1'b1;
    m_fr64 = m_rises % 64 == 63;
    m_fr4 = m_rises % 4 == 3;
    m_rises++;
  endtask
  task automatic model_step(input bit r, input bit e, input bit w, input logic [7:0] v);
    int nv;
    nv = v == 0 ? 1 : int'(v);
    if (r) begin
      m_run = 0; m_t = 0; m_div = 20; m_pv = 0; m_pend = 0; m_rises = 0;
      m_rise = 0; m_fall = 0; m_fr64 = 0; m_fr4 = 0; rh = '0; fh = '0;
    end else begin
      rh = {rh[DLY-2:0], m_rise};
      fh = {fh[DLY-2:0], m_fall};
      m_rise = 0; m_fall = 0; m_fr64 = 0; m_fr4 = 0;
      if (!m_run) begin
        if (w) m_div = nv;
        if (e) start_period();
      end else begin
        m_t++;
        if (m_t == m_div) m_fall = 1;
        if (m_t == 2 * m_div) begin
          if (m_pv) begin
            m_div = m_pend;
            m_pv = 0;
          end
          if (e) start_period();
          else begin
            m_run = 0;
            m_rises = 0;
          end
        end
        if (w) begin
          m_pend = nv;
          m_pv = 1;
        end
      end
    end
  endtask
  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      chk("M_CLK", i, 8'(mclk[i]), 8'(m_run && m_t < m_div));
      chk("m_clk_rising", i, 8'(rise[i]), 8'(m_rise));
      chk("m_clk_falling", i, 8'(fall[i]), 8'(m_fall));
      chk("sample_l", i, 8'(sl[i]), 8'(rh[DLY-1]));
      chk("sample_r", i, 8'(sr[i]), 8'(fh[DLY-1]));
      chk("frame_tick", i, 8'(frame[i]), 8'(i == 0 ? m_fr64 : m_fr4));
      chk("running", i, 8'(run[i]), 8'(m_run));
    end
    chk("cfg_pending", 0, 8'(ifa.cfg_pending), 8'(m_pv));
    chk("cfg_pending", 1, 8'(ifb.cfg_pending), 8'(m_pv));
    chk("div_active", 0, ifa.div_active, 8'(m_div));
    chk("div_active", 1, ifb.div_active, 8'(m_div));
  endtask
  task automatic cyc(input bit r, input bit e, input bit w, input logic [7:0] v);
    rst = r;
    en = e;
    ifa.cfg_wr = w;
    ifa.cfg_div = v;
    @(posedge clk);
    model_step(r, e, w, v);
    @(negedge clk);
    check_all();
  endtask
  initial begin
    bit e;
    repeat (3) cyc(1, 0, 0, 0);
    repeat (8) cyc(0, 1, 0, 0);
    cyc(0, 1, 1, 5);
    repeat (80) cyc(0, 1, 0, 0);
    cyc(0, 1, 1, 20);
    repeat (43) cyc(0, 1, 0, 0);
    repeat (60) cyc(0, 0, 0, 0);
    repeat (700) cyc(0, 1, 0, 0);
    repeat (60) cyc(0, 0, 0, 0);
    repeat (700) cyc(0, 1, 0, 0);
    repeat (60) cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    repeat (200) cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 20);
    repeat (5) cyc(0, 0, 0, 0);
    repeat (10) cyc(0, 1, 0, 0);
    cyc(1, 1, 0, 0);
    repeat (10) cyc(0, 1, 0, 0);
    e = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 49) == 0) e = ~e;
      cyc($urandom_range(0, 399) == 0, e, $urandom_range(0, 19) == 0, 8'($urandom_range(0, 7)));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pdm_mclk_ctrl.md
Name: pdm_mclk_ctrl

Overview:
Programmable PDM microphone clock controller, successor to the fixed-divide PDM clock generator.
- Produces M_CLK from the system clock with a runtime-programmable half-period.
- Starts and stops M_CLK cleanly, with no glitches on enable changes or divider updates.
- Emits delayed per-edge sample strobes for stereo PDM capture: left channel on the rising edge, right channel on the falling edge.
- Emits a decimation frame tick that feeds the downstream CIC decimators.

Parameters:
INPUT_FREQ, 100_000_000, system clock frequency in Hz
OUTPUT_FREQ, 2_400_000, default M_CLK frequency in Hz
DIV_W, 8, width of the half-period divider
DIV_DEFAULT, INPUT_FREQ/OUTPUT_FREQ/2 (=20), half-period in clk cycles after reset
SAMPLE_DLY, 3, clk cycles from an M_CLK edge strobe to its sample strobe (0 = coincident)
DECIM, 64, M_CLK rising edges per frame_tick (must be >= 1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
en  in  1  run request, synchronous to clk
cfg_wr  in  1  one-cycle write strobe for cfg_div
cfg_div  in  DIV_W  requested half-period in clk cycles
cfg_pending  out  1  a written divider is waiting to be applied
div_active  out  DIV_W  half-period currently in use
M_CLK  out  1  PDM clock to the microphones
m_clk_rising  out  1  one-cycle pulse, coincident with M_CLK going high
m_clk_falling  out  1  one-cycle pulse, coincident with M_CLK going low
sample_l  out  1  m_clk_rising delayed by SAMPLE_DLY cycles
sample_r  out  1  m_clk_falling delayed by SAMPLE_DLY cycles
frame_tick  out  1  one-cycle pulse on every DECIM-th rising edge
running  out  1  high while state is not IDLE

Behaviour:
- Reset values: all outputs 0, except div_active = DIV_DEFAULT.
  - Internally: state = IDLE, cnt = 0, rise counter = 0, pending register cleared, delay lines cleared.
- All outputs are registered.
- States: IDLE, HIGH, LOW.
  - IDLE:
    - M_CLK = 0.
    - If en = 1: next cycle goes to HIGH with M_CLK = 1, m_clk_rising = 1, cnt = 0.
  - HIGH:
    - cnt increments each cycle.
    - When cnt == div_active-1: go to LOW with M_CLK = 0, m_clk_falling = 1, cnt = 0.
  - LOW:
    - When cnt == div_active-1: apply any pending divider.
    - Then, if en = 1: go to HIGH and pulse m_clk_rising.
    - Else: go to IDLE.
- Period timing: HIGH lasts div_active cycles and LOW lasts div_active cycles, so the period is 2*div_active.
- Deasserting en never truncates a phase; the current period always completes its LOW phase.
- Divider update:
  - cfg_wr latches cfg_div into the pending register and sets cfg_pending the next cycle.
  - A value of 0 is stored as 1.
  - In IDLE, the divider is applied on the cycle after cfg_wr and cfg_pending stays 0.
  - While running, the divider is applied only at the LOW-phase end. div_active updates and cfg_pending clears on that cycle.
  - A cfg_wr while a value is pending overwrites it; last write wins.
  - A cfg_wr on the same cycle the pending value is applied: the new value becomes pending for the next period.
- Sample strobes:
  - Each strobe is a SAMPLE_DLY-stage shift register fed by the matching edge strobe.
  - Strobes already in flight still emerge after a stop to IDLE.
  - SAMPLE_DLY is not checked against div_active.
- Frame tick:
  - The rise counter counts from 0 to DECIM-1 and increments with each m_clk_rising.
  - frame_tick is asserted together with the m_clk_rising for which the pre-increment count == DECIM-1; the counter then wraps to 0.
  - The counter is cleared on entry to IDLE, so every run starts a fresh frame.
  - With DECIM = 1, every rising edge produces a frame_tick.
- Mid-operation reset: the state returns to IDLE within 1 cycle, M_CLK = 0, and all strobes and the pending value are dropped.

Decomposition:
- Package pdm_pkg:
  - state enum {IDLE, HIGH, LOW}.
  - DIV_W default.
  - DIV_DEFAULT computation function.
- Sub-module pdm_strobe_delay: parameterised SAMPLE_DLY pulse delay line with synchronous reset. It is instantiated twice, once for sample_l and once for sample_r.

Test Plan:
- Defaults, en = 1 from IDLE → M_CLK rises 1 cycle later; 20 cycles high, 20 low; m_clk_rising every 40 cycles; sample_l 3 cycles after each rise.
- Running at 20, cfg_wr cfg_div = 5 at high cycle 7 → cfg_pending = 1; current period stays 20/20; next period 5/5; cfg_pending clears and div_active = 5 at the LOW end.
- en dropped at high cycle 3 → remaining 17 high and 20 low cycles complete; no further rise; running = 0 after the LOW end; final sample_r still appears.
- DECIM = 4, div 20 → frame_tick on the 4th, 8th and 12th rises (every 160 cycles); stop then restart → first tick on the 4th rise after restart.
- cfg_div = 0 written in IDLE, then en = 1 → div_active = 1; M_CLK toggles every cycle; every rise and fall produces a strobe.
- rst asserted mid-HIGH → next cycle M_CLK = 0, running = 0, div_active = 20, no strobes.
  - With en held, M_CLK restarts 1 cycle after rst releases.
